// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, command/result types and ALU timing for the command sequencer
package alu_pkg;
  typedef enum logic [1:0] {ADD, SUB, INV, ROR} alu_op_e;
  typedef struct packed {
    logic signed [3:0] a;
    logic signed [3:0] b;
    alu_op_e           op;
    logic [1:0]        tag;
  } alu_cmd_t;
  typedef struct packed {
    logic signed [4:0] c;
    alu_op_e           op;
    logic [1:0]        tag;
  } alu_res_t;
  localparam int ALU_LATENCY = 1;
endpackage

// File: rtl/alu_sync_fifo.sv
// alu_sync_fifo: power-of-two deep synchronous FIFO carrying an arbitrary packed type
module alu_sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output T                         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign w_push  = i_push && (r_cnt < (AW+1)'(DEPTH));
  assign w_pop   = i_pop && (r_cnt != '0);
  assign o_data  = r_mem[r_rp];
  assign o_count = r_cnt;
  assign o_empty = (r_cnt == '0);
  // pointers wrap naturally at DEPTH; push and pop together leave the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // storage needs no reset: the count alone decides what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: queues ALU commands, issues them under result-FIFO credit, and collects tagged results in order
module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic signed [3:0] cmd_a,
  input  logic signed [3:0] cmd_b,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_tag,
  output logic signed [3:0] alu_a,
  output logic signed [3:0] alu_b,
  output logic [1:0]        alu_opcode,
  input  logic signed [4:0] alu_c,
  output logic              res_valid,
  input  logic              res_ready,
  output logic signed [4:0] res_c,
  output logic [1:0]        res_tag,
  output logic [1:0]        res_op
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PL = ALU_LATENCY + 1;
  alu_cmd_t w_cmd_in, w_cmd_head;
  alu_res_t w_res_in, w_res_head;
  logic [CW-1:0] w_cmd_cnt, w_res_cnt;
  logic w_cmd_empty, w_res_empty, w_push, w_issue;
  logic [PL-1:0] r_v;
  alu_op_e r_op [PL];
  logic [1:0] r_tag [PL];
  assign cmd_ready = !rst && (w_cmd_cnt < CW'(DEPTH));
  assign w_push    = cmd_valid && cmd_ready;
  assign w_cmd_in  = '{a: cmd_a, b: cmd_b, op: alu_op_e'(cmd_op), tag: cmd_tag};
  assign w_issue   = !w_cmd_empty && (int'(w_res_cnt) + $countones(r_v) < DEPTH);
  assign w_res_in  = '{c: alu_c, op: r_op[PL-1], tag: r_tag[PL-1]};
  assign res_valid = !w_res_empty;
  assign res_c     = w_res_head.c;
  assign res_tag   = w_res_head.tag;
  assign res_op    = w_res_head.op;
  alu_sync_fifo #(.T(alu_cmd_t), .DEPTH(DEPTH)) u_cmd_fifo (
    .clk(clk), .rst(rst), .i_push(w_push), .i_data(w_cmd_in), .i_pop(w_issue),
    .o_data(w_cmd_head), .o_count(w_cmd_cnt), .o_empty(w_cmd_empty)
  );
  alu_sync_fifo #(.T(alu_res_t), .DEPTH(DEPTH)) u_res_fifo (
    .clk(clk), .rst(rst), .i_push(r_v[PL-1]), .i_data(w_res_in), .i_pop(res_valid && res_ready),
    .o_data(w_res_head), .o_count(w_res_cnt), .o_empty(w_res_empty)
  );
  // operand registers feeding the ALU load only on issue and hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (w_issue) begin
      alu_a      <= w_cmd_head.a;
      alu_b      <= w_cmd_head.b;
      alu_opcode <= w_cmd_head.op;
    end
  end
  // valid shift register tracks issued commands until their ALU result is captured
  always_ff @(posedge clk) begin
    if (rst) r_v <= '0;
    else r_v <= {r_v[PL-2:0], w_issue};
  end
  // tag/op travel alongside the valid bits; they only matter where the valid is set
  always_ff @(posedge clk) begin
    r_op[0]  <= w_cmd_head.op;
    r_tag[0] <= w_cmd_head.tag;
    for (int i = 1; i < PL; i++) begin
      r_op[i]  <= r_op[i-1];
      r_tag[i] <= r_tag[i-1];
    end
  end
endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed and random checks of alu_cmd_seq against a registered ALU and scoreboard
module tb_alu_cmd_seq;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, cmd_valid = 0, res_ready = 0;
  logic cmd_ready, res_valid;
  logic signed [3:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b;
  logic [1:0] cmd_op = 0, cmd_tag = 0, alu_opcode, res_tag, res_op;
  logic signed [4:0] alu_c, res_c;
  int errors = 0, checks = 0, popped = 0, base;
  typedef struct {logic signed [4:0] c; logic [1:0] op; logic [1:0] tag;} exp_t;
  exp_t sb [$];
  int ba [4] = '{-8, 3, 0, -1};
  int bb [4] = '{7, 0, 4, -1};
  int bop [4] = '{1, 2, 3, 0};
  int bc [4] = '{-15, -4, 1, -2};

  always #5 clk = ~clk;

  alu_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_c(res_c), .res_tag(res_tag), .res_op(res_op)
  );

  function automatic logic signed [4:0] ref_alu(input logic signed [3:0] a, input logic signed [3:0] b, input logic [1:0] op);
    case (op)
      2'd0: return {a[3], a} + {b[3], b};
      2'd1: return {a[3], a} - {b[3], b};
      2'd2: return ~{a[3], a};
      default: return {4'b0, |b};
    endcase
  endfunction

  // downstream ALU: one register stage
  always @(posedge clk) alu_c <= ref_alu(alu_a, alu_b, alu_opcode);

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int v, input int a, input int b, input int op, input int tag);
    cmd_valid = 1'(v);
    cmd_a = 4'(a);
    cmd_b = 4'(b);
    cmd_op = 2'(op);
    cmd_tag = 2'(tag);
  endtask

  task automatic send(input int a, input int b, input int op, input int tag);
    logic acc;
    int n = 0;
    drive(1, a, b, op, tag);
    do begin
      acc = cmd_ready;
      step;
      n++;
    end while (!acc && n < 30);
    chk("send_accept", acc, 1);
    cmd_valid = 0;
  endtask

  // scoreboard: expected results queued at acceptance, compared at every result pop
  always @(posedge clk) begin
    if (rst) sb.delete();
    else begin
      chk("res_capture_full", dut.r_v[1] && dut.u_res_fifo.o_count == 3'(DEPTH), 0);
      if (res_valid && res_ready) begin
        chk("res_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          chk("res_c", res_c, sb[0].c);
          chk("res_tag", res_tag, sb[0].tag);
          chk("res_op", res_op, sb[0].op);
          void'(sb.pop_front());
          popped++;
        end
      end
      if (cmd_valid && cmd_ready) sb.push_back('{ref_alu(cmd_a, cmd_b, cmd_op), cmd_op, cmd_tag});
    end
  end

  initial begin
    step;
    step;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_opcode, 0);
    rst = 0;
    #1;
    chk("cmd_ready_after_rst", cmd_ready, 1);
    res_ready = 1;
    step;
    drive(1, 7, 7, 0, 1);
    step;
    cmd_valid = 0;
    chk("add_lat_e0", res_valid, 0);
    step;
    chk("add_issue_alu_a", alu_a, 7);
    chk("add_lat_e1", res_valid, 0);
    step;
    chk("add_lat_e2", res_valid, 0);
    step;
    chk("add_valid_e3", res_valid, 1);
    chk("add_res_c", res_c, 14);
    chk("add_tag", res_tag, 1);
    step;
    chk("add_drained", res_valid, 0);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        drive(1, ba[k], bb[k], bop[k], k);
        chk("burst_ready", cmd_ready, 1);
      end else cmd_valid = 0;
      step;
      if (k >= 3 && k < 7) begin
        chk("burst_valid", res_valid, 1);
        chk("burst_c", res_c, bc[k-3]);
        chk("burst_tag", res_tag, k - 3);
      end
      if (k == 7) chk("burst_end", res_valid, 0);
    end
    res_ready = 0;
    base = popped;
    for (int i = 0; i < 2 * DEPTH; i++) send(i, 1, 0, i);
    step;
    step;
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_res_count", dut.u_res_fifo.o_count, DEPTH);
    chk("bp_cmd_count", dut.u_cmd_fifo.o_count, DEPTH);
    chk("bp_head", res_c, 1);
    chk("bp_alu_a_hold", alu_a, 3);
    drive(1, 5, 0, 0, 0);
    res_ready = 1;
    chk("fb_ready_a", cmd_ready, 0);
    step;
    chk("fb_ready_b", cmd_ready, 0);
    step;
    chk("fb_ready_after", cmd_ready, 1);
    chk("fb_cmd_count", dut.u_cmd_fifo.o_count, DEPTH - 1);
    step;
    cmd_valid = 0;
    for (int n = 0; n < 60 && (sb.size() != 0 || res_valid); n++) step;
    chk("bp_all_delivered", popped - base, 2 * DEPTH + 1);
    chk("bp_sb_empty", sb.size(), 0);
    res_ready = 0;
    for (int i = 0; i < 2 * DEPTH; i++) send(1, 2, 1, i);
    step;
    step;
    res_ready = 1;
    step;
    step;
    res_ready = 0;
    drive(1, 2, 2, 0, 3);
    step;
    cmd_valid = 0;
    chk("mid_in_flight", $countones(dut.r_v), 2);
    chk("mid_queued", dut.u_cmd_fifo.o_count, 3);
    rst = 1;
    step;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    chk("mid_rst_alu_op", alu_opcode, 0);
    rst = 0;
    res_ready = 1;
    for (int n = 0; n < 8; n++) begin
      step;
      chk("no_stale", res_valid, 0);
    end
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3));
      res_ready = 1'($urandom_range(0, 1));
      step;
    end
    cmd_valid = 0;
    res_ready = 1;
    for (int n = 0; n < 60 && (sb.size() != 0 || res_valid); n++) step;
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_res_valid", res_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 4, power of two >=2: entries in each of the command and result FIFOs.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  upstream command present.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_a, cmd_b  input  4 each  signed operands.
REQ-007 cmd_op  input  2  opcode: 00 add, 01 sub, 10 invert A, 11 reduction-OR of B.
REQ-008 cmd_tag  input  2  caller tag, returned unchanged with the result.
REQ-009 alu_a, alu_b  output  4 each  operands driven to the downstream registered ALU.
REQ-010 alu_opcode  output  2  opcode driven to the ALU.
REQ-011 alu_c  input  5  signed ALU result; the ALU has exactly one register stage.
REQ-012 res_valid  output  1  result available.
REQ-013 res_ready  input  1  consumer accepts the result.
REQ-014 res_c  output  5  signed result; res_tag  output  2; res_op  output  2.

Function
REQ-015 Command transfer SHALL occur on a posedge where cmd_valid && cmd_ready; {a,b,op,tag} is pushed into the command FIFO.
REQ-016 cmd_ready SHALL equal (command FIFO count < DEPTH), independent of same-cycle pops.
REQ-017 Issue SHALL occur on a posedge where the command FIFO is non-empty and (result FIFO count + in_flight) < DEPTH; the head entry is popped.
REQ-018 On issue, alu_a/alu_b/alu_opcode SHALL be registered from the head entry; when not issuing they hold their previous value.
REQ-019 A 2-stage valid/tag/op pipeline SHALL track each issue; in_flight = number of set valid bits (0..2).
REQ-020 alu_c SHALL be captured into the result FIFO on the second posedge after the issue edge, together with its tag and op.
REQ-021 Minimum latency: command accepted at edge E0, issued at E1, ALU computes at E2, captured at E3; res_valid high in the cycle after E3.
REQ-022 Sustained throughput SHALL be one command per cycle when res_ready is held high.
REQ-023 res_valid = result FIFO non-empty; res_c/res_tag/res_op show the head entry and stay stable while res_valid && !res_ready.
REQ-024 Pop of the result FIFO SHALL occur on res_valid && res_ready.
REQ-025 Simultaneous push and pop on either FIFO SHALL leave the count unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-026 The credit rule (REQ-017) SHALL guarantee that a capture never finds the result FIFO full; no result is ever dropped.
REQ-027 Results SHALL leave in command acceptance order.
REQ-028 No arithmetic is done in this block; res_c is alu_c verbatim.

Reset
REQ-029 While rst is high at a posedge: both FIFOs empty, pointers 0, pipeline valids 0, alu_a/alu_b/alu_opcode = 0, res_valid = 0, cmd_ready = 0.
REQ-030 cmd_ready SHALL go to 1 in the first cycle after rst deasserts.
REQ-031 Reset mid-operation SHALL discard all queued and in-flight commands; alu_c values that arrive after reset are never captured.

Structure
REQ-032 Shared package alu_pkg SHALL hold: enum alu_op_e {ADD, SUB, INV, ROR}, struct alu_cmd_t {a, b, op, tag}, struct alu_res_t {c, op, tag}, and constant ALU_LATENCY = 1.
REQ-033 One parameterised sub-module, alu_sync_fifo (data type, DEPTH), SHALL be instantiated twice: once for commands, once for results.
REQ-034 Target size: 150-300 lines of RTL in total.

Verification
REQ-035 ADD: a=7, b=7, tag=1, res_ready=1 -> res_c=14, tag 1, res_valid rises 3 cycles after acceptance.
REQ-036 Back-to-back burst: SUB -8-7, INV a=3, ROR b=4'b0100, ADD -1+-1 -> res_c = -15, -4, 1, -2 in order, tags match, one per cycle.
REQ-037 Backpressure: res_ready=0 and 2*DEPTH commands offered -> exactly DEPTH results queued, issue stalls, cmd_ready=0 once the command FIFO holds DEPTH; after release all 2*DEPTH results arrive in order and none are lost.
REQ-038 Full-boundary: command FIFO full, then one pop and one offered push in the same cycle -> cmd_ready stays 0 that cycle and the count drops to DEPTH-1.
REQ-039 Reset with 2 in flight and 3 queued -> next cycle res_valid=0, alu_* = 0, and no stale result ever appears.
REQ-040 Random stimulus with random res_ready against a scoreboard model: order, tags, and values match, and the result FIFO never overflows.
